tt_dfd_vid_req_scheduler: RTL and testbench
===========================================

Name: tt_dfd_vid_req_scheduler

Overview:
- Serialises debug requests raised per virtual hart ID (VID) onto a shared per-physical-hart request/ack channel.
- Translates each VID to its physical ID (PID) using the fuse map and VID map.
- Arbitrates round-robin among pending VIDs, issues one request at a time, and waits for ack or timeout.
- Returns a per-request response with status. Sits between the DFD debug-request front end and the per-core debug interfaces.

Parameters:
NumHarts, 8, number of harts (virtual and physical)
NumHartsIdx, (NumHarts==1)?1:$clog2(NumHarts), VID/PID index width
TimeoutW, 8, width of the timeout counter and of timeout_cycles

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
fuse_map  input  NumHarts  1 = physical hart i present; quasi-static, changes only while busy=0
vid_map  input  NumHarts x NumHartsIdx  VID assigned to physical hart i; quasi-static
timeout_cycles  input  TimeoutW  ack timeout in cycles; 0 = timeout disabled
req_vid_vector  input  NumHarts  one-cycle set pulse per VID; sets the pending bit
pending  output  NumHarts  registered pending mask, indexed by VID
busy  output  1  state != IDLE
hart_req_vector  output  NumHarts  one-hot request to physical hart, indexed by PID
hart_ack  input  NumHarts  per-PID ack; only bit [latched PID] is sampled, and only in REQ
resp_valid  output  1  one-cycle response pulse
resp_vid  output  NumHartsIdx  VID being answered; valid with resp_valid
resp_status  output  2  00 OK, 01 UNMAPPED, 10 TIMEOUT, 11 reserved

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset values: state=IDLE, pending=0, rr_ptr=0, cnt=0, cur_vid=0, cur_pid=0, cur_status=00. All outputs are 0.
- VID->PID mapping, combinational:
  - For each physical i with fuse_map[i]=1: entry[vid_map[i]] = {pid=i, mapped=1}.
  - If two present harts share a VID, the higher i wins.
  - A VID with no entry is unmapped.
- Pending register, per bit, in priority order:
  - req pulse sets the bit.
  - The RESP-state clear applies only to cur_vid.
  - If a set and a clear hit the same bit in the same cycle, set wins, so the request is re-queued.
- Arbitration, in IDLE when pending != 0:
  - Select the first set bit scanning from rr_ptr upward, wrapping modulo NumHarts.
  - Latch cur_vid and the mapped cur_pid.
- States:
  - IDLE: if pending==0, stay. Otherwise arbitrate. If the selected VID is mapped, go to REQ with cnt=0. If unmapped, set cur_status=01 and go to RESP without touching any hart.
  - REQ: hart_req_vector = one-hot(cur_pid), derived from registered state and cur_pid only.
    - hart_ack[cur_pid]=1: cur_status=00, go to RESP.
    - Else, timeout_cycles!=0 and cnt==timeout_cycles-1: cur_status=10, go to RESP.
    - Else cnt++. cnt saturates and never wraps.
    - Ack and timeout in the same cycle: ack wins (status 00).
  - RESP: for one cycle, resp_valid=1, resp_vid=cur_vid, resp_status=cur_status. Clear pending[cur_vid]. rr_ptr = cur_vid+1, wrapping NumHarts-1 -> 0. Go to IDLE.
- hart_req_vector is 0 in every state other than REQ. resp_* are 0 outside RESP.
- Latency:
  - A req pulse in cycle t makes pending visible in t+1. IDLE selects in t+1. hart_req is asserted from t+2.
  - Ack in cycle a gives resp_valid in a+1, and IDLE in a+2.
  - Minimum spacing between two issued requests is 3 cycles (REQ->RESP->IDLE->REQ).
- Timeout with timeout_cycles=N: hart_req is held exactly N cycles, then RESP.
- Acks on any non-selected PID are ignored. Acks outside REQ are ignored.
- A reset assertion mid-transaction drops hart_req_vector and clears pending immediately; no response is generated.
- NumHarts=1: rr_ptr stays 0. The arbiter degenerates to a single bit.

Test Plan:
- Common setup: NumHarts=8, fuse_map=8'hFE, vid_map[i]=i-1 for i=1..7 (so VID v maps to PID v+1; VID 7 is unmapped), timeout_cycles=4.
- Basic: req_vid_vector=8'h08 pulse at cycle 0 -> hart_req_vector=8'h10 from cycle 2. hart_ack[4] at cycle 5 -> resp_valid at cycle 6 with resp_vid=3, status=00. pending=0 at cycle 7.
- Round-robin: pulse 8'h05 -> VID 0 is served first (hart_req 8'h02), then VID 2 (8'h08). While VID 2 is in REQ, pulse 8'h01 -> after VID 2 completes (rr_ptr=3), VID 0 is served next.
- Unmapped: pulse 8'h80 -> hart_req_vector stays 0. resp_valid 2 cycles after the pulse with resp_vid=7, status=01.
- Timeout: VID 1 requested with no ack -> hart_req_vector=8'h04 for exactly 4 cycles, then status=10. Repeat with timeout_cycles=0 -> request held 100 cycles until an ack arrives, status=00.
- Collisions:
  - Ack coincident with the last timeout cycle -> status=00.
  - A req pulse for cur_vid during RESP -> pending bit stays set and the VID is re-served.
  - An ack on a wrong PID -> ignored.
- Reset: assert reset_n=0 while in REQ with pending=8'h0A -> all outputs and pending are 0 asynchronously. After release, there is no resp_valid.

Source files
------------

// File: rtl/tt_dfd_vid_req_scheduler.sv
// Debug request scheduler: collects per-VID request pulses and translates each
// VID to its physical hart. It then issues one request at a time, round-robin,
// on the shared per-PID request/ack channel. Every request gets one response,
// which reports OK, UNMAPPED or TIMEOUT.
module tt_dfd_vid_req_scheduler #(
    parameter int NumHarts    = 8,
    parameter int NumHartsIdx = (NumHarts == 1) ? 1 : $clog2(NumHarts),
    parameter int TimeoutW    = 8
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [NumHarts-1:0]                   fuse_map,
    input  logic [NumHarts-1:0][NumHartsIdx-1:0]  vid_map,
    input  logic [TimeoutW-1:0]                   timeout_cycles,
    input  logic [NumHarts-1:0]                   req_vid_vector,
    output logic [NumHarts-1:0]                   pending,
    output logic                                  busy,
    output logic [NumHarts-1:0]                   hart_req_vector,
    input  logic [NumHarts-1:0]                   hart_ack,
    output logic                                  resp_valid,
    output logic [NumHartsIdx-1:0]                resp_vid,
    output logic [1:0]                            resp_status
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] STS_OK       = 2'b00;
    localparam logic [1:0] STS_UNMAPPED = 2'b01;
    localparam logic [1:0] STS_TIMEOUT  = 2'b10;

    // The VID lookup table covers every encodable VID, so a vid_map entry can
    // never index outside the table, even when NumHarts is not a power of two.
    localparam int MapSize = 1 << NumHartsIdx;

    function automatic logic [NumHarts-1:0] onehot(input logic [NumHartsIdx-1:0] idx);
        logic [NumHarts-1:0] vec;
        vec      = {NumHarts{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // Registered state
    logic [1:0]             state_r;
    logic [NumHarts-1:0]    pending_r;
    logic [NumHartsIdx-1:0] rr_ptr_r;
    logic [TimeoutW-1:0]    cnt_r;
    logic [NumHartsIdx-1:0] cur_vid_r;
    logic [NumHartsIdx-1:0] cur_pid_r;
    logic [1:0]             cur_status_r;
    logic                   busy_r;
    logic [NumHarts-1:0]    hart_req_r;
    logic                   resp_valid_r;
    logic [NumHartsIdx-1:0] resp_vid_r;
    logic [1:0]             resp_status_r;

    // Next-state values
    logic [1:0]             state_nxt_s;
    logic [NumHarts-1:0]    pending_nxt_s;
    logic [NumHartsIdx-1:0] rr_ptr_nxt_s;
    logic [TimeoutW-1:0]    cnt_nxt_s;
    logic [NumHartsIdx-1:0] cur_vid_nxt_s;
    logic [NumHartsIdx-1:0] cur_pid_nxt_s;
    logic [1:0]             cur_status_nxt_s;

    // Lookup and arbitration results
    logic [MapSize-1:0][NumHartsIdx-1:0] map_pid_s;
    logic [MapSize-1:0]                  map_ok_s;
    logic [NumHartsIdx-1:0]              cand_s;
    logic [NumHartsIdx-1:0]              sel_vid_s;
    logic                                sel_found_s;
    logic [NumHarts-1:0]                 pend_clr_s;

    // Build the VID->PID table from the present harts. When two present harts
    // share a VID, the later (higher) index wins.
    always_comb begin
        map_pid_s = {MapSize{{NumHartsIdx{1'b0}}}};
        map_ok_s  = {MapSize{1'b0}};
        for (int i = 0; i < NumHarts; i++) begin
            map_pid_s[vid_map[i]] = fuse_map[i] ? NumHartsIdx'(i) : map_pid_s[vid_map[i]];
            map_ok_s[vid_map[i]]  = map_ok_s[vid_map[i]] | fuse_map[i];
        end
    end

    // Round-robin pick: scan for the first pending VID at or after rr_ptr,
    // wrapping at NumHarts.
    always_comb begin
        cand_s      = {NumHartsIdx{1'b0}};
        sel_vid_s   = {NumHartsIdx{1'b0}};
        sel_found_s = 1'b0;
        for (int k = 0; k < NumHarts; k++) begin
            cand_s      = NumHartsIdx'((int'(rr_ptr_r) + k) % NumHarts);
            sel_vid_s   = (!sel_found_s && pending_r[cand_s]) ? cand_s : sel_vid_s;
            sel_found_s = sel_found_s | pending_r[cand_s];
        end
    end

    // Update the pending mask: a response clears its own VID. A new pulse in
    // the same cycle re-sets the bit, so that VID is queued again.
    always_comb begin
        pend_clr_s    = (state_r == ST_RESP) ? onehot(cur_vid_r) : {NumHarts{1'b0}};
        pending_nxt_s = (pending_r & ~pend_clr_s) | req_vid_vector;
    end

    // Controller FSM: IDLE picks a VID, REQ waits for ack or timeout, and RESP
    // reports the result for one cycle.
    always_comb begin
        state_nxt_s      = state_r;
        rr_ptr_nxt_s     = rr_ptr_r;
        cnt_nxt_s        = cnt_r;
        cur_vid_nxt_s    = cur_vid_r;
        cur_pid_nxt_s    = cur_pid_r;
        cur_status_nxt_s = cur_status_r;
        case (state_r)
            ST_IDLE: begin
                if (sel_found_s) begin
                    cur_vid_nxt_s = sel_vid_s;
                    cur_pid_nxt_s = map_pid_s[sel_vid_s];
                    cnt_nxt_s     = {TimeoutW{1'b0}};
                    if (map_ok_s[sel_vid_s]) begin
                        state_nxt_s = ST_REQ;
                    end else begin
                        cur_status_nxt_s = STS_UNMAPPED;
                        state_nxt_s      = ST_RESP;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (hart_ack[cur_pid_r]) begin
                    cur_status_nxt_s = STS_OK;
                    state_nxt_s      = ST_RESP;
                end else if ((timeout_cycles != {TimeoutW{1'b0}}) &&
                             (cnt_r == (timeout_cycles - TimeoutW'(1)))) begin
                    cur_status_nxt_s = STS_TIMEOUT;
                    state_nxt_s      = ST_RESP;
                end else if (cnt_r != {TimeoutW{1'b1}}) begin
                    cnt_nxt_s = cnt_r + TimeoutW'(1);
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_RESP: begin
                rr_ptr_nxt_s = (cur_vid_r == NumHartsIdx'(NumHarts - 1)) ?
                               {NumHartsIdx{1'b0}} : (cur_vid_r + NumHartsIdx'(1));
                state_nxt_s  = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers. Outputs are computed from the next state,
    // so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            pending_r     <= {NumHarts{1'b0}};
            rr_ptr_r      <= {NumHartsIdx{1'b0}};
            cnt_r         <= {TimeoutW{1'b0}};
            cur_vid_r     <= {NumHartsIdx{1'b0}};
            cur_pid_r     <= {NumHartsIdx{1'b0}};
            cur_status_r  <= STS_OK;
            busy_r        <= 1'b0;
            hart_req_r    <= {NumHarts{1'b0}};
            resp_valid_r  <= 1'b0;
            resp_vid_r    <= {NumHartsIdx{1'b0}};
            resp_status_r <= 2'b00;
        end else begin
            state_r       <= state_nxt_s;
            pending_r     <= pending_nxt_s;
            rr_ptr_r      <= rr_ptr_nxt_s;
            cnt_r         <= cnt_nxt_s;
            cur_vid_r     <= cur_vid_nxt_s;
            cur_pid_r     <= cur_pid_nxt_s;
            cur_status_r  <= cur_status_nxt_s;
            busy_r        <= (state_nxt_s != ST_IDLE);
            hart_req_r    <= (state_nxt_s == ST_REQ) ? onehot(cur_pid_nxt_s) : {NumHarts{1'b0}};
            resp_valid_r  <= (state_nxt_s == ST_RESP);
            resp_vid_r    <= (state_nxt_s == ST_RESP) ? cur_vid_nxt_s : {NumHartsIdx{1'b0}};
            resp_status_r <= (state_nxt_s == ST_RESP) ? cur_status_nxt_s : 2'b00;
        end
    end

    assign pending         = pending_r;
    assign busy            = busy_r;
    assign hart_req_vector = hart_req_r;
    assign resp_valid      = resp_valid_r;
    assign resp_vid        = resp_vid_r;
    assign resp_status     = resp_status_r;

endmodule

// File: tb/tb_tt_dfd_vid_req_scheduler.sv
// Directed bench for tt_dfd_vid_req_scheduler: table-driven per-cycle vectors
// plus hand-written no-timeout and mid-transaction reset sequences.
module tb_tt_dfd_vid_req_scheduler;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [7:0]      fuse_map;
    logic [7:0][2:0] vid_map;
    logic [7:0]      timeout_cycles;
    logic [7:0]      req_vid_vector;
    logic [7:0]      pending;
    logic            busy;
    logic [7:0]      hart_req_vector;
    logic [7:0]      hart_ack;
    logic            resp_valid;
    logic [2:0]      resp_vid;
    logic [1:0]      resp_status;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] req;
        logic [7:0] ack;
        logic [7:0] pend;
        logic       busy;
        logic [7:0] hreq;
        logic       rv;
        logic [2:0] rvid;
        logic [1:0] st;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    tt_dfd_vid_req_scheduler #(.NumHarts(8), .TimeoutW(8)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .fuse_map        (fuse_map),
        .vid_map         (vid_map),
        .timeout_cycles  (timeout_cycles),
        .req_vid_vector  (req_vid_vector),
        .pending         (pending),
        .busy            (busy),
        .hart_req_vector (hart_req_vector),
        .hart_ack        (hart_ack),
        .resp_valid      (resp_valid),
        .resp_vid        (resp_vid),
        .resp_status     (resp_status)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] pend, input logic bsy,
                             input logic [7:0] hreq, input logic rv,
                             input logic [2:0] rvid, input logic [1:0] st);
        cmp($sformatf("%s pending", tag),     32'(pending),         32'(pend));
        cmp($sformatf("%s busy", tag),        32'(busy),            32'(bsy));
        cmp($sformatf("%s hart_req", tag),    32'(hart_req_vector), 32'(hreq));
        cmp($sformatf("%s resp_valid", tag),  32'(resp_valid),      32'(rv));
        cmp($sformatf("%s resp_vid", tag),    32'(resp_vid),        32'(rvid));
        cmp($sformatf("%s resp_status", tag), 32'(resp_status),     32'(st));
    endtask

    function automatic void add(input logic [7:0] req, input logic [7:0] ack,
                                input logic [7:0] pend, input logic bsy,
                                input logic [7:0] hreq, input logic rv,
                                input logic [2:0] rvid, input logic [1:0] st);
        vec_t e;
        e.req = req; e.ack = ack; e.pend = pend; e.busy = bsy;
        e.hreq = hreq; e.rv = rv; e.rvid = rvid; e.st = st;
        vecs.push_back(e);
    endfunction

    initial begin
        reset_n        = 1'b0;
        fuse_map       = 8'hFE;
        vid_map[0]     = 3'd0;
        for (int i = 1; i < 8; i++) vid_map[i] = 3'(i - 1);
        timeout_cycles = 8'd4;
        req_vid_vector = 8'h00;
        hart_ack       = 8'h00;

        // Columns: req, ack | pending, busy, hart_req, resp_valid, resp_vid, status
        // Basic: VID3 -> PID4; the ack also lands on the last timeout cycle, so ack wins.
        add(8'h08, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 2'b00);
        add(8'h00, 8'h00, 8'h08, 1'b0, 8'h00, 1'b0, 3'd0, 2'b00);
        add(8'h00, 8'h00, 8'h08, 1'b1, 8'h10, 1'b0, 3'd0, 2'b00);
        add(8'h00, 8'h00, 8'h08, 1'b1, 8'h10, 1'b0, 3'd0, 2'b00);
        add(8'h00, 8'h00, 8'h08, 1'b1, 8'h10, 1'b0, 3'd0, 2'b00);
        add(8'h00, 8'h10, 8'h08, 1'b1, 8'h10, 1'b0, 3'd0, 2'b00);
        add(8'h00, 8'h00, 8'h08, 1'b1, 8'h00, 1'b1, 3'd3, 2'b00);
        add(8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 2'b00);
        // Round-robin: VIDs 0 and 2, then VID0 again after rr_ptr moves to 3; wrong-PID acks ignored.
        add(8'h05, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 2'b00);
        add(8'h00, 8'h00, 8'h05, 1'b0, 8'h00, 1'b0, 3'd0, 2'b00);
        add(8'h00, 8'h00, 8'h05, 1'b1, 8'h02, 1'b0, 3'd0, 2'b00);
        add(8'h00, 8'h02, 8'h05, 1'b1, 8'h02, 1'b0, 3'd0, 2'b00);
        add(8'h00, 8'h00, 8'h05, 1'b1, 8'h00, 1'b1, 3'd0, 2'b00);
        add(8'h00, 8'h00, 8'h04, 1'b0, 8'h00, 1'b0, 3'd0, 2'b00);
        add(8'h00, 8'h00, 8'h04, 1'b1, 8'h08, 1'b0, 3'd0, 2'b00);
        add(8'h01, 8'h04, 8'h04, 1'b1, 8'h08, 1'b0, 3'd0, 2'b00);
        add(8'h00, 8'h08, 8'h05, 1'b1, 8'h08, 1'b0, 3'd0, 2'b00);
        add(8'h00, 8'h00, 8'h05, 1'b1, 8'h00, 1'b1, 3'd2, 2'b00);
        add(8'h00, 8'h00, 8'h01, 1'b0, 8'h00, 1'b0, 3'd0, 2'b00);
        add(8'h00, 8'hFD, 8'h01, 1'b1, 8'h02, 1'b0, 3'd0, 2'b00);
        add(8'h00, 8'h02, 8'h01, 1'b1, 8'h02, 1'b0, 3'd0, 2'b00);
        add(8'h00, 8'h00, 8'h01, 1'b1, 8'h00, 1'b1, 3'd0, 2'b00);
        add(8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 2'b00);
        // Unmapped VID7: no hart request, status 01; an ack during RESP is ignored.
        add(8'h80, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 2'b00);
        add(8'h00, 8'h00, 8'h80, 1'b0, 8'h00, 1'b0, 3'd0, 2'b00);
        add(8'h00, 8'hFF, 8'h80, 1'b1, 8'h00, 1'b1, 3'd7, 2'b01);
        add(8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 2'b00);
        // Timeout: VID1 -> PID2 is held for exactly 4 cycles, then status 10.
        add(8'h02, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 2'b00);
        add(8'h00, 8'h00, 8'h02, 1'b0, 8'h00, 1'b0, 3'd0, 2'b00);
        add(8'h00, 8'h00, 8'h02, 1'b1, 8'h04, 1'b0, 3'd0, 2'b00);
        add(8'h00, 8'h00, 8'h02, 1'b1, 8'h04, 1'b0, 3'd0, 2'b00);
        add(8'h00, 8'h00, 8'h02, 1'b1, 8'h04, 1'b0, 3'd0, 2'b00);
        add(8'h00, 8'h00, 8'h02, 1'b1, 8'h04, 1'b0, 3'd0, 2'b00);
        add(8'h00, 8'h00, 8'h02, 1'b1, 8'h00, 1'b1, 3'd1, 2'b10);
        add(8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 2'b00);
        // Re-queue: a pulse for VID4 during its own RESP keeps pending set and re-serves it.
        add(8'h10, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 2'b00);
        add(8'h00, 8'h00, 8'h10, 1'b0, 8'h00, 1'b0, 3'd0, 2'b00);
        add(8'h00, 8'h00, 8'h10, 1'b1, 8'h20, 1'b0, 3'd0, 2'b00);
        add(8'h00, 8'h20, 8'h10, 1'b1, 8'h20, 1'b0, 3'd0, 2'b00);
        add(8'h10, 8'h00, 8'h10, 1'b1, 8'h00, 1'b1, 3'd4, 2'b00);
        add(8'h00, 8'h00, 8'h10, 1'b0, 8'h00, 1'b0, 3'd0, 2'b00);
        add(8'h00, 8'h00, 8'h10, 1'b1, 8'h20, 1'b0, 3'd0, 2'b00);
        add(8'h00, 8'h20, 8'h10, 1'b1, 8'h20, 1'b0, 3'd0, 2'b00);
        add(8'h00, 8'h00, 8'h10, 1'b1, 8'h00, 1'b1, 3'd4, 2'b00);
        add(8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 2'b00);

        // Reset state
        #12;
        check_all("reset", 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 2'b00);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven vectors: drive after the edge, check at the falling edge.
        for (int v = 0; v < vecs.size(); v++) begin
            req_vid_vector = vecs[v].req;
            hart_ack       = vecs[v].ack;
            @(negedge clk);
            check_all($sformatf("vec%0d", v), vecs[v].pend, vecs[v].busy, vecs[v].hreq,
                      vecs[v].rv, vecs[v].rvid, vecs[v].st);
            @(posedge clk); #1;
        end
        req_vid_vector = 8'h00;
        hart_ack       = 8'h00;

        // Timeout disabled: VID5 -> PID6 is held for 100 cycles until the ack.
        timeout_cycles = 8'd0;
        req_vid_vector = 8'h20;
        @(posedge clk); #1;
        req_vid_vector = 8'h00;
        @(posedge clk); #1;
        for (int i = 0; i < 100; i++) begin
            hart_ack = (i == 99) ? 8'h40 : 8'h00;
            @(negedge clk);
            cmp($sformatf("notimeout hold%0d", i), 32'(hart_req_vector), 32'h40);
            @(posedge clk); #1;
        end
        hart_ack = 8'h00;
        @(negedge clk);
        check_all("notimeout resp", 8'h20, 1'b1, 8'h00, 1'b1, 3'd5, 2'b00);
        @(posedge clk); #1;
        @(negedge clk);
        check_all("notimeout idle", 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 2'b00);
        @(posedge clk); #1;
        timeout_cycles = 8'd4;

        // Reset in the middle of a request with pending 0A: everything drops, no response.
        req_vid_vector = 8'h0A;
        @(posedge clk); #1;
        req_vid_vector = 8'h00;
        @(posedge clk); #1;
        @(negedge clk);
        check_all("prereset", 8'h0A, 1'b1, 8'h04, 1'b0, 3'd0, 2'b00);
        #2;
        reset_n = 1'b0;
        #1;
        check_all("midreset", 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 2'b00);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check_all($sformatf("postreset%0d", i), 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 2'b00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
